// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM port arbiter: FSM state encoding and
// default RAM address/data widths.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_t;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection, purely combinational.
// Ports: req (request vector), last (previous winner index) ->
//        vld (some request present), idx (winner index).
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               vld,
  output logic [IDX_W-1:0]   idx
);

  // Walk candidates from lowest to highest priority so the highest-priority
  // one (last+1) is the final assignment and wins.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[(int'(last) + i) % NUM_REQ]) begin
        vld = 1'b1;
        idx = IDX_W'((int'(last) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates NUM_REQ requesters onto one single-port RAM with round-robin
// priority. One transaction at a time: IDLE picks and latches a winner,
// ISSUE drives the RAM command and gnt, RDATA returns read data with rvalid.
// Ports: clk, rst_n (async, active-low); req/req_we/req_addr/req_wdata per
// requester; gnt/rvalid one-hot pulses, shared rdata, busy; ram_* RAM port.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rvalid,
  output logic [DATA_W-1:0]              rdata,
  output logic                           busy,
  output logic                           ram_rd_en,
  output logic                           ram_wr_en,
  output logic [ADDR_W-1:0]              ram_addr,
  output logic [DATA_W-1:0]              ram_wdata,
  input  logic [DATA_W-1:0]              ram_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_q,  last_d;
  logic                we_q,    we_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                pick_vld;
  logic [IDX_W-1:0]    pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req  (req),
    .last (last_q),
    .vld  (pick_vld),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Outputs decode from registered state only; req never reaches the RAM
  // strobes in the same cycle. Command fields are zeroed outside ISSUE so
  // the RAM bus is quiet when idle.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    gnt       = '0;
    rvalid    = '0;
    rdata     = '0;
    ram_rd_en = 1'b0;
    ram_wr_en = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          we_d    = req_we[pick_idx];
          addr_d  = req_addr[pick_idx];
          wdata_d = req_wdata[pick_idx];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        gnt       = NUM_REQ'(1) << owner_q;
        ram_rd_en = ~we_q;
        ram_wr_en = we_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        last_d    = owner_q;
        state_d   = we_q ? IDLE : RDATA;
      end
      RDATA: begin
        // RAM read port is registered: data for the ISSUE-cycle read is
        // present now.
        rvalid  = NUM_REQ'(1) << owner_q;
        rdata   = ram_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule
